// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the debouncer and its synchronizer.
package debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        WAIT   = 1'b1
    } debounce_state_e;

    // Wide enough to hold stable_count_p itself, so the count never wraps.
    function automatic int debounce_cnt_width(input int stable_count);
        return $clog2(stable_count + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reusable for any raw input.
module sync_2ff #(
    parameter logic reset_val_p = 1'b0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // NOTE: sequential state uses non-blocking assignments so s1_q -> s2_q shifts by one flop per edge.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            s1_q <= reset_val_p;
            s2_q <= reset_val_p;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/debounce_sync.sv
// Debounces a raw input: synchronize, require stable_count_p qualified disagreeing samples, then commit.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int   stable_count_p = 16,
    parameter logic reset_val_p    = 1'b0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic btn_i,
    input  logic en_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int                  cnt_w_lp    = debounce_cnt_width(stable_count_p);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(stable_count_p - 1);
    localparam logic [cnt_w_lp-1:0] one_lp      = cnt_w_lp'(1);

    logic                  s2;
    debounce_state_e       state_q;
    logic [cnt_w_lp-1:0]   count_q;
    logic                  level_q;
    logic                  rise_q;
    logic                  fall_q;

    sync_2ff #(
        .reset_val_p(reset_val_p)
    ) u_sync (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .d_i      (btn_i),
        .q_o      (s2)
    );

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= STABLE;
            count_q <= '0;
            level_q <= reset_val_p;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                STABLE: begin
                    if (en_i && (s2 != level_q)) begin
                        state_q <= WAIT;
                        count_q <= one_lp;
                    end else begin
                        count_q <= '0;
                    end
                end
                WAIT: begin
                    // Any edge where the input agrees with the level again is a glitch; drop the run.
                    if (s2 == level_q) begin
                        state_q <= STABLE;
                        count_q <= '0;
                    end else if (en_i && (count_q == last_cnt_lp)) begin
                        state_q <= STABLE;
                        count_q <= '0;
                        level_q <= s2;
                        rise_q  <= s2;
                        fall_q  <= ~s2;
                    end else if (en_i) begin
                        count_q <= count_q + one_lp;
                    end
                end
                default: begin
                    state_q <= STABLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Randomized and directed bench for debounce_sync, scored against a run-length reference model.
module tb_debounce_sync;
    import debounce_pkg::*;

    localparam int N = 4;

    typedef struct {
        bit is_rise;
        int edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic en = 1'b1;
    logic btn1 = 1'b1;

    logic level0, rise0, fall0;
    logic level1, rise1, fall1;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;

    exp_t sb_q[$];

    // Reference model state: 2-edge input delay plus a run of qualified disagreeing samples.
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;
    bit m_level = 1'b0;
    int m_run = 0;

    always #5 clk = ~clk;

    debounce_sync #(.stable_count_p(N), .reset_val_p(1'b0)) dut0 (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .btn_i    (btn),
        .en_i     (en),
        .level_o  (level0),
        .rise_o   (rise0),
        .fall_o   (fall0)
    );

    debounce_sync #(.stable_count_p(N), .reset_val_p(1'b1)) dut1 (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .btn_i    (btn1),
        .en_i     (en),
        .level_o  (level1),
        .rise_o   (rise1),
        .fall_o   (fall1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        edge_cnt++;
        if (!rst_n) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            m_level = 1'b0;
            m_run = 0;
        end else begin
            if (m_s2 == m_level) begin
                m_run = 0;
            end else if (en) begin
                m_run++;
                if (m_run == N) begin
                    m_level = m_s2;
                    sb_q.push_back('{is_rise: m_s2, edge_no: edge_cnt});
                    m_run = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        check("level", 32'(level0), 32'(m_level));
        if (rise0 && fall0) check("rise_fall_overlap", 32'(1), 32'(0));
        if (sb_q.size() > 0 && sb_q[0].edge_no < edge_cnt) begin
            e = sb_q.pop_front();
            check("missing_pulse_edge", 32'(0), 32'(e.edge_no));
        end
        if (rise0 || fall0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 32'(1), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("pulse_is_rise", 32'(rise0), 32'(e.is_rise));
                check("pulse_edge", 32'(edge_cnt), 32'(e.edge_no));
            end
        end
        check("rv1_level", 32'(level1), 32'(1));
        check("rv1_no_pulse", 32'({rise1, fall1}), 32'(0));
    end

    initial begin
        int start;
        int seen;

        // Reset
        step(3);
        check("reset_level0", 32'(level0), 32'(0));
        check("reset_pulses0", 32'({rise0, fall0}), 32'(0));
        check("reset_level1", 32'(level1), 32'(1));
        rst_n = 1'b1;
        step(4);

        // Clean rise: commit visible after edge N+2
        btn = 1'b1;
        step(N + 1);
        check("rise_not_early", 32'(level0), 32'(0));
        step(1);
        check("rise_level", 32'(level0), 32'(1));
        check("rise_pulse", 32'(rise0), 32'(1));
        step(1);
        check("rise_cleared", 32'(rise0), 32'(0));

        // Fall then back-to-back rise
        btn = 1'b0;
        step(N + 2);
        check("fall_pulse", 32'(fall0), 32'(1));
        check("fall_level", 32'(level0), 32'(0));
        btn = 1'b1;
        step(N + 2);
        check("b2b_rise_pulse", 32'(rise0), 32'(1));
        btn = 1'b0;
        step(N + 4);
        check("b2b_fall_level", 32'(level0), 32'(0));

        // Glitch of 3 cycles is rejected
        btn = 1'b1;
        step(3);
        btn = 1'b0;
        step(6);
        check("glitch_level", 32'(level0), 32'(0));
        check("glitch_count", 32'(dut0.count_q), 32'(0));
        check("glitch_state", 32'(dut0.state_q), 32'(STABLE));

        // en_i every 4th cycle: commit on 4th qualified tick after s2 rises
        seen = -1;
        for (int i = 0; i < 40; i++) begin
            en = (i % 4 == 3);
            btn = 1'b1;
            @(negedge clk);
            if (level0 && seen < 0) seen = i + 1;
        end
        check("en_gate_latency", 32'(seen), 32'(16));
        en = 1'b1;

        // Reset mid-WAIT
        btn = 1'b0;
        step(N + 4);
        btn = 1'b1;
        step(4);
        check("midwait_count", 32'(dut0.count_q), 32'(2));
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("midwait_level", 32'(level0), 32'(0));
        check("midwait_pulses", 32'({rise0, fall0}), 32'(0));
        check("midwait_state", 32'(dut0.state_q), 32'(STABLE));
        start = edge_cnt;
        step(N + 1);
        check("midwait_restart_early", 32'(level0), 32'(0));
        step(1);
        check("midwait_restart_rise", 32'(rise0), 32'(1));
        check("midwait_restart_edge", 32'(edge_cnt - start), 32'(N + 2));

        // Randomized bouncing with random sample ticks and occasional reset
        for (int c = 0; c < 3000; ) begin
            int hold;
            int en_mode;
            hold = $urandom_range(1, 10);
            en_mode = $urandom_range(0, 2);
            btn = 1'($urandom_range(0, 1));
            for (int k = 0; k < hold; k++) begin
                en = (en_mode == 0) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
                rst_n = ($urandom_range(0, 399) != 0);
                @(negedge clk);
                c++;
            end
        end

        // Drain: hold a steady input long enough for any pending commit
        rst_n = 1'b1;
        en = 1'b1;
        step(2 * N + 6);
        check("scoreboard_empty", 32'(sb_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Consumes a raw, asynchronous single-bit input (button, switch, external strobe) and produces a clean, clock-domain-synchronous level plus single-cycle rise and fall pulses.
- Sits directly upstream of the enable/data pins of the team's single-bit flip-flop and counter stages, so that downstream `en_i`/`d_i` never see metastable or bouncing values.
- Internally it is a 2-flop synchronizer, a stability counter and a 2-state FSM.

Parameters:
- `stable_count_p`, default 16: number of consecutive `en_i`-qualified samples that must disagree with the current level before the level changes. Legal range is >= 2.
- `reset_val_p`, default 1'b0: reset value of the synchronizer flops and of `level_o`.

Ports:
- `clk_i`  input  1  clock, rising edge.
- `reset_n_i`  input  1  reset, synchronous, active-low. The block is in reset on every rising edge where `reset_n_i` = 0.
- `btn_i`  input  1  raw asynchronous input.
- `en_i`  input  1  sample tick, e.g. from a prescaler. When 0, the counter holds.
- `level_o`  output  1  debounced level.
- `rise_o`  output  1  one-cycle pulse when `level_o` goes 0->1.
- `fall_o`  output  1  one-cycle pulse when `level_o` goes 1->0.

Behaviour:
- **Reset** (edge with `reset_n_i`=0):
  - Both sync flops and `level_o` <= `reset_val_p`.
  - `rise_o` and `fall_o` <= 0.
  - Count <= 0, state <= STABLE.
  - All outputs are registered, so none toggles spuriously when reset is released.
- **Synchronizer:**
  - `btn_i` -> s1 -> s2 on every edge.
  - s2 is the only version of the input used by the logic; `en_i` does not gate it.
- **Counter:** width is `$clog2(stable_count_p+1)`. It never exceeds `stable_count_p-1`, so no wrap-around is possible.
- **FSM state STABLE:**
  - If `en_i`=1 and s2 != `level_o`: state <= WAIT, count <= 1.
  - Otherwise hold, with count = 0.
- **FSM state WAIT** (checked in priority order):
  1. s2 == `level_o` on any edge, regardless of `en_i`: abort. State <= STABLE, count <= 0, no pulse. This is glitch rejection.
  2. `en_i`=1 and count == `stable_count_p-1`: commit. `level_o` <= s2. `rise_o` <= s2, `fall_o` <= ~s2. Count <= 0, state <= STABLE.
  3. `en_i`=1 otherwise: count <= count+1.
  4. `en_i`=0: hold.
- **Pulses:**
  - Asserted on the same cycle that `level_o` first shows its new value.
  - Cleared on the next edge unconditionally.
  - `rise_o` and `fall_o` are never high together.
- **Latency** with `en_i` tied to 1 and N = `stable_count_p`:
  - Number edges from 1, where edge 1 is the first edge that samples a new stable `btn_i` value.
  - s2 shows the new value after edge 2. WAIT is entered at edge 3. Commit happens at edge N+2.
  - `level_o` and the pulse are visible after edge N+2.
- **Throughput:**
  - After a commit the FSM is back in STABLE, so an opposite transition can begin counting on the very next qualified sample.
  - Minimum spacing between pulses is N `en_i` ticks.
- **Reset mid-WAIT:** count and state are discarded, and `level_o` returns to `reset_val_p` with no pulse.
- **Simultaneous events:** reset dominates everything. On an abort edge the count never increments.

Decomposition:
- Package `debounce_pkg` holds:
  - the state enum `debounce_state_e` {STABLE, WAIT}, 1 bit;
  - a helper function or localparam computing the counter width from `stable_count_p`.
- Sub-module `sync_2ff`:
  - two flops in series, with parameter `reset_val_p` and ports `clk_i`, `reset_n_i`, `d_i`, `q_o`;
  - reusable for other asynchronous inputs.
- The top level contains the counter, the FSM and the output registers.

Test Plan:
- **Clean rise** (N=4, `en_i`=1, `reset_val_p`=0): set `btn_i`=1 before edge 1 and hold it. `level_o`=1 and `rise_o`=1 appear after edge 6. `rise_o`=0 after edge 7, and `fall_o` stays 0 throughout.
- **Glitch reject** (N=4): `btn_i` is high for 3 cycles, then low. `level_o` stays 0 and there is no pulse. An internal probe shows count returning to 0.
- **`en_i` gating** (N=4, `en_i` high every 4th cycle): hold `btn_i`=1. `level_o` rises exactly on the 4th qualified tick after s2 goes high, which is about 16 cycles, and never earlier.
- **Fall and back-to-back:** after the rise, drop `btn_i` to 0 and hold it. `fall_o` pulses after 6 edges. Then raise `btn_i` again: `rise_o` pulses 6 edges later, and the two pulses never overlap.
- **Reset mid-WAIT:** with count=2, drive `reset_n_i`=0 for 1 edge. After that edge, `level_o`=0, no pulse, state=STABLE. With `btn_i` still high, the full N+2 latency restarts.
- **`reset_val_p`=1:** with `btn_i`=1 during and after reset, `level_o`=1 and no `fall_o` or `rise_o` pulse occurs after reset is released.
